// File: rtl/rdata_demux.sv
// AXI read-data demux: rotates beats across NUM_CH plane FIFOs per group.
// Optional saturating error-beat counter under RDATA_DEMUX_ERRCNT_EN.
module rdata_demux #(
  parameter int DATA_W   = 1024,
  parameter int ID_WIDTH = 2,
  parameter int NUM_CH   = 3,
  parameter int GRP_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        m_axi_rdata,
  input  logic [ID_WIDTH-1:0]      m_axi_rid,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  input  logic [1:0]               m_axi_rresp,
  output logic                     m_axi_rready,
  input  logic                     start_pulse,
  input  logic [GRP_W-1:0]         num_groups,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_error,
  output logic                     frame_error,
  output logic [15:0]              err_cnt,
  output logic [NUM_CH*DATA_W-1:0] ch_fifo_din,
  output logic [NUM_CH-1:0]        ch_fifo_wr,
  input  logic [NUM_CH-1:0]        ch_fifo_full
);

  localparam int IW = $clog2(NUM_CH);
  localparam logic [IW-1:0] LAST = IW'(NUM_CH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   r_state;
  logic [IW-1:0]            r_idx;
  logic [GRP_W-1:0]         r_ngrp;
  logic [GRP_W-1:0]         r_grp;
  logic                     r_done;
  logic                     r_rd_err;
  logic                     r_fr_err;
  logic [NUM_CH*DATA_W-1:0] r_din;
  logic [NUM_CH-1:0]        r_wr;

  logic w_run;
  logic w_full_idx;
  logic w_rready;
  logic w_acc;
  logic w_at_last;
  logic w_grp_end;
  logic w_fin;
  logic w_unused;

  assign w_unused = ^m_axi_rid;

  always_comb begin
    w_full_idx = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (r_idx == IW'(i)) w_full_idx = ch_fifo_full[i];
  end

  assign w_run     = (r_state == RUN);
  assign w_rready  = w_run & ~w_full_idx & ~start_pulse;
  assign w_acc     = m_axi_rvalid & w_rready;
  assign w_at_last = (r_idx == LAST);
  // early rlast closes the group just like a natural wrap
  assign w_grp_end = w_at_last | m_axi_rlast;
  assign w_fin     = w_grp_end &
                     (r_grp == r_ngrp - GRP_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_ngrp   <= '0;
      r_grp    <= '0;
      r_done   <= 1'b0;
      r_rd_err <= 1'b0;
      r_fr_err <= 1'b0;
      r_din    <= '0;
      r_wr     <= '0;
    end else begin
      r_done <= 1'b0;
      r_wr   <= '0;
      if (start_pulse) begin
        r_ngrp   <= num_groups;
        r_idx    <= '0;
        r_grp    <= '0;
        r_rd_err <= 1'b0;
        r_fr_err <= 1'b0;
        if (num_groups != '0) begin
          r_state <= RUN;
        end else begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end else if (w_acc) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (r_idx == IW'(i)) begin
            r_din[i*DATA_W +: DATA_W] <= m_axi_rdata;
            r_wr[i] <= 1'b1;
          end
        end
        if (m_axi_rresp != 2'b00) r_rd_err <= 1'b1;
        if (m_axi_rlast ^ w_at_last) r_fr_err <= 1'b1;
        if (w_grp_end) begin
          r_idx <= '0;
          r_grp <= r_grp + GRP_W'(1);
        end else begin
          r_idx <= r_idx + IW'(1);
        end
        if (w_fin) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end
    end
  end

`ifdef RDATA_DEMUX_ERRCNT_EN
  logic [15:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (start_pulse) begin
      r_err_cnt <= '0;
    end else if (w_acc && m_axi_rresp != 2'b00 &&
                 r_err_cnt != 16'hFFFF) begin
      r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

  assign m_axi_rready = w_rready;
  assign busy         = w_run;
  assign done         = r_done;
  assign rd_error     = r_rd_err;
  assign frame_error  = r_fr_err;
  assign ch_fifo_din  = r_din;
  assign ch_fifo_wr   = r_wr;

endmodule

// File: doc/rdata_demux.md
RDATA_DEMUX -- requirements
Module: rdata_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 1024, AXI read data and FIFO data width.
REQ-002 SHALL have parameter ID_WIDTH, default 2, AXI ID width.
REQ-003 SHALL have parameter NUM_CH, default 3, number of output plane FIFOs and beats per group (≥2).
REQ-004 SHALL have parameter GRP_W, default 16, width of the group count.
REQ-005 SHALL have ports: clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: m_axi_rdata  in  DATA_W; m_axi_rid  in  ID_WIDTH (ignored); m_axi_rlast  in  1; m_axi_rvalid  in  1; m_axi_rresp  in  2; m_axi_rready  out  1.
REQ-007 SHALL have ports: start_pulse  in  1  job start; num_groups  in  GRP_W  groups in job, sampled on start_pulse; busy  out  1; done  out  1  one-cycle job-end pulse.
REQ-008 SHALL have ports: rd_error  out  1  sticky nonzero-rresp flag; frame_error  out  1  sticky rlast misalignment flag; err_cnt  out  16  nonzero-rresp beat count.
REQ-009 SHALL have ports: ch_fifo_din  out  NUM_CH*DATA_W (channel i at bits [i*DATA_W +: DATA_W]); ch_fifo_wr  out  NUM_CH; ch_fifo_full  in  NUM_CH, programmable-full, asserted when ≤1 free entry remains.

Function
REQ-010 SHALL implement states IDLE and RUN.
REQ-011 IDLE: m_axi_rready=0. On start_pulse, latch num_groups, clear beat index idx, group counter, rd_error, frame_error and err_cnt; if num_groups≠0 go to RUN, else pulse done next cycle and stay in IDLE.
REQ-012 RUN: busy=1; m_axi_rready = ~ch_fifo_full[idx] & ~start_pulse.
REQ-013 Accept = m_axi_rvalid & m_axi_rready. Each accepted beat SHALL be registered to ch_fifo_din slice idx, with ch_fifo_wr[idx]=1 the following cycle (latency 1). Other slices SHALL hold their value; other wr bits SHALL be 0.
REQ-014 On accept, idx SHALL increment and wrap from NUM_CH-1 to 0. Each wrap SHALL increment the group counter.
REQ-015 On accept of the beat that completes group num_groups, the block SHALL return to IDLE and pulse done in the next cycle, concurrent with the final ch_fifo_wr.
REQ-016 rlast on an accepted beat with idx≠NUM_CH-1 SHALL set frame_error, set idx to 0, and count a completed group. No rlast when idx=NUM_CH-1 SHALL set frame_error; idx wraps normally.
REQ-017 An accepted beat with m_axi_rresp≠0 SHALL set rd_error, which stays set until the next start_pulse or reset. Data SHALL still be written.
REQ-018 start_pulse in RUN SHALL abort and restart the job per REQ-011. No beat is accepted in that cycle, and done is not pulsed for the aborted job.
REQ-019 A full assertion on a channel other than idx SHALL NOT stall m_axi_rready.

Reset
REQ-020 On rst_n low, all outputs SHALL be 0 (ch_fifo_din all-zero, ch_fifo_wr=0, m_axi_rready=0, busy=0, done=0, flags=0, err_cnt=0), state=IDLE, idx=0, group counter=0.
REQ-021 Reset asserted mid-job SHALL abandon the job with no done pulse. Any write pending for the next cycle SHALL be dropped.

Configuration
REQ-022 With macro RDATA_DEMUX_ERRCNT_EN defined, err_cnt SHALL increment on each accepted beat with rresp≠0, saturate at 16'hFFFF, and clear on start_pulse.
REQ-023 Without RDATA_DEMUX_ERRCNT_EN, err_cnt SHALL be constant 0 and no counter logic SHALL be present. rd_error is unaffected.

Verification
REQ-024 NUM_CH=3, num_groups=2, 6 back-to-back beats D0..D5 with rlast on beats 2 and 5 -> wr pattern 001,010,100,001,010,100 one cycle after each accept; done pulses together with the final write; busy falls.
REQ-025 ch_fifo_full=3'b010 while idx=1 for 4 cycles -> m_axi_rready=0 for those 4 cycles; accepts resume when full drops; a full bit on channels 0 or 2 alone causes no stall while idx=1.
REQ-026 rresp=2'b10 on beat 1 of 3 -> rd_error=1 from the next cycle and held; err_cnt=1 with the macro, 0 without; the next start_pulse clears both.
REQ-027 rlast on beat 1 of a 3-beat group -> frame_error=1; the next beat goes to channel 0; the group counter advances.
REQ-028 start_pulse with num_groups=0 -> done one cycle later, busy stays 0, m_axi_rready stays 0.
REQ-029 rst_n pulsed low mid-group -> all outputs 0 immediately, no ch_fifo_wr and no done afterwards, and the next job starts at channel 0.
